// File: rtl/bkm_pkg.sv
// Shared constants for the BKM shift-and-add engine: digit codes and FSM state encoding.
package bkm_pkg;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;
    localparam logic [1:0] DIG_RSV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The reserved code is deliberately folded into "zero" so a stray code never moves x.
    function automatic logic dig_is_nonzero(input logic [1:0] d);
        logic nz;
        case (d)
            DIG_POS, DIG_NEG:  nz = 1'b1;
            DIG_ZERO, DIG_RSV: nz = 1'b0;
            default:           nz = 1'b0;
        endcase
        return nz;
    endfunction

endpackage

// File: rtl/bkm_shift_add_iter_if.sv
// Digit/operand bus between the upstream digit selector (master) and the shift-add engine (slave).
interface bkm_shift_add_iter_if #(
    parameter int W = 16
);
    logic                ena;
    logic                start;
    logic signed [W-1:0] x0;
    logic                dig_valid;
    logic [1:0]          dig_d;
    logic                dig_ready;
    logic                busy;
    logic                done;
    logic signed [W-1:0] x;
    logic                ovf;

    modport master (
        output ena, start, x0, dig_valid, dig_d,
        input  dig_ready, busy, done, x, ovf
    );

    modport slave (
        input  ena, start, x0, dig_valid, dig_d,
        output dig_ready, busy, done, x, ovf
    );
endinterface

// File: rtl/add_subb.sv
// Signed adder with independent negation of either operand: s = (+/-a) + (+/-b), wrapping modulo 2^W.
module add_subb #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                subb_a,
    input  logic                subb_b,
    output logic signed [W-1:0] s
);
    logic [W-1:0] a_op;
    logic [W-1:0] b_op;
    logic [W-1:0] cin_a;
    logic [W-1:0] cin_b;

    // Two's-complement negation as invert plus carry-in.
    always_comb begin
        a_op  = a ^ {W{subb_a}};
        b_op  = b ^ {W{subb_b}};
        cin_a = {{(W-1){1'b0}}, subb_a};
        cin_b = {{(W-1){1'b0}}, subb_b};
        s     = a_op + b_op + cin_a + cin_b;
    end
endmodule

// File: rtl/bkm_shift_add_iter.sv
// Iterative BKM step engine: x <= x + d_n * (x >>> n), one signed digit per handshake.
// Optional macro BKM_SHIFT_ADD_SAT_EN saturates overflowing steps instead of wrapping.
module bkm_shift_add_iter
    import bkm_pkg::*;
#(
    parameter int W      = 16,
    parameter int N_ITER = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bkm_shift_add_iter_if.slave bus
);
    localparam int             NW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [NW-1:0]  N_LAST = NW'(N_ITER - 1);
`ifdef BKM_SHIFT_ADD_SAT_EN
    localparam logic [W-1:0]   X_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   X_MIN  = {1'b1, {(W-1){1'b0}}};
`endif

    state_e              state_q, state_d;
    logic [NW-1:0]       n_q, n_d;
    logic signed [W-1:0] x_q, x_d;
    logic                ovf_q, ovf_d;

    logic signed [W-1:0] shifted;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] step_val;
    logic                subb;
    logic                b_eff_sign;
    logic                step_ovf;

    add_subb #(.W(W)) u_add_subb (
        .a      (x_q),
        .b      (shifted),
        .subb_a (1'b0),
        .subb_b (subb),
        .s      (sum)
    );

    // The effective b sign is the bit actually fed into the adder, so subtraction overflow is exact.
    always_comb begin
        shifted    = x_q >>> n_q;
        subb       = (bus.dig_d == DIG_NEG);
        b_eff_sign = shifted[W-1] ^ subb;
        step_ovf   = (x_q[W-1] == b_eff_sign) && (sum[W-1] != x_q[W-1]);
`ifdef BKM_SHIFT_ADD_SAT_EN
        if (step_ovf) begin
            step_val = x_q[W-1] ? X_MIN : X_MAX;
        end else begin
            step_val = sum;
        end
`else
        step_val = sum;
`endif
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        x_d     = x_q;
        ovf_d   = ovf_q;
        if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_d     = bus.x0;
                        n_d     = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.dig_valid) begin
                        if (dig_is_nonzero(bus.dig_d)) begin
                            x_d   = step_val;
                            ovf_d = ovf_q | step_ovf;
                        end
                        n_d = n_q + NW'(1);
                        if (n_q == N_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status outputs decode the registered state; ena gates the handshake and the done pulse.
    always_comb begin
        bus.dig_ready = (state_q == ST_RUN) && bus.ena;
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE) && bus.ena;
        bus.x         = x_q;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_bkm_shift_add_iter.sv
// Directed self-checking bench for bkm_shift_add_iter at W=8, N_ITER=4.
module tb_bkm_shift_add_iter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bkm_shift_add_iter_if #(.W(8)) bus ();

    bkm_shift_add_iter #(.W(8), .N_ITER(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef BKM_SHIFT_ADD_SAT_EN
    localparam logic signed [7:0] OVF_X = 8'sd127;
`else
    localparam logic signed [7:0] OVF_X = -8'sd56;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic signed [7:0] v);
        bus.start = 1'b1;
        bus.x0    = v;
        step();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [1:0] d);
        bus.dig_valid = 1'b1;
        bus.dig_d     = d;
        step();
        bus.dig_valid = 1'b0;
        bus.dig_d     = 2'b00;
    endtask

    task automatic wait_done(output int waited);
        waited = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                waited = k;
                break;
            end
            step();
        end
    endtask

    // Full run: digits packed d0 in [1:0]; optional valid gap after digit 1 and ena drop after digit 2.
    task automatic run_seq(input logic signed [7:0] x0v, input logic [7:0] digs,
                           input int gap, input bit ena_off,
                           output logic signed [7:0] x1, output logic signed [7:0] x2,
                           output logic signed [7:0] x3, output logic signed [7:0] x4,
                           output int lat, output int stall_done,
                           output int ready_ena_low, output int pulses);
        int edges;
        int waited;
        stall_done    = 0;
        ready_ena_low = 0;
        pulses        = 0;
        lat           = -1;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        launch(x0v);
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            feed(digs[2*i +: 2]);
            edges++;
            if (i == 0) x1 = bus.x;
            if (i == 1) x2 = bus.x;
            if (i == 2) x3 = bus.x;
            if (i == 3) x4 = bus.x;
            if (i == 0) begin
                for (int g = 0; g < gap; g++) begin
                    if (bus.done) stall_done++;
                    step();
                    edges++;
                end
            end
            if (i == 1 && ena_off) begin
                bus.ena       = 1'b0;
                bus.dig_valid = 1'b1;
                #1;
                if (bus.dig_ready || bus.done) ready_ena_low++;
                step();
                edges++;
                bus.ena       = 1'b1;
                bus.dig_valid = 1'b0;
            end
        end
        wait_done(waited);
        if (waited >= 0) begin
            lat    = edges + waited + 1;
            pulses = 1;
            step();
            if (bus.done) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.ena       = 1'b1;
        bus.start     = 1'b0;
        bus.x0        = '0;
        bus.dig_valid = 1'b0;
        bus.dig_d     = 2'b00;
        #3;
        total++; if (bus.x !== 8'sd0) begin bad++; $display("[TB] FAIL reset_x got=%0d want=0", bus.x); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.dig_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", bus.dig_ready); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", bus.ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic signed [7:0] x1, x2, x3, x4;
        int lat, sd, rl, pulses;
        run_seq(8'sd32, 8'b01_11_00_01, 0, 1'b0, x1, x2, x3, x4, lat, sd, rl, pulses);
        total++; if (x1 !== 8'sd64) begin bad++; $display("[TB] FAIL basic_x1 got=%0d want=64", x1); end
        total++; if (x2 !== 8'sd64) begin bad++; $display("[TB] FAIL basic_x2 got=%0d want=64", x2); end
        total++; if (x3 !== 8'sd48) begin bad++; $display("[TB] FAIL basic_x3 got=%0d want=48", x3); end
        total++; if (x4 !== 8'sd54) begin bad++; $display("[TB] FAIL basic_x4 got=%0d want=54", x4); end
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=5", lat); end
        total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL basic_done_pulses got=%0d want=1", pulses); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL basic_ovf got=%b want=0", bus.ovf); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after got=%b want=0", bus.busy); end
    endtask

    task automatic test_negative();
        logic signed [7:0] x1, x2, x3, x4;
        int lat, sd, rl, pulses;
        run_seq(-8'sd40, 8'b11_00_01_00, 0, 1'b0, x1, x2, x3, x4, lat, sd, rl, pulses);
        total++; if (x1 !== -8'sd40) begin bad++; $display("[TB] FAIL neg_x1 got=%0d want=-40", x1); end
        total++; if (x2 !== -8'sd60) begin bad++; $display("[TB] FAIL neg_x2 got=%0d want=-60", x2); end
        total++; if (x3 !== -8'sd60) begin bad++; $display("[TB] FAIL neg_x3 got=%0d want=-60", x3); end
        total++; if (x4 !== -8'sd52) begin bad++; $display("[TB] FAIL neg_x4 got=%0d want=-52", x4); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL neg_ovf got=%b want=0", bus.ovf); end
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL neg_latency got=%0d want=5", lat); end
    endtask

    task automatic test_overflow();
        logic signed [7:0] x1, x2, x3, x4;
        int lat, sd, rl, pulses, waited;
        run_seq(8'sd100, 8'b00_00_00_01, 0, 1'b0, x1, x2, x3, x4, lat, sd, rl, pulses);
        total++; if (x1 !== OVF_X) begin bad++; $display("[TB] FAIL ovf_x1 got=%0d want=%0d", x1, OVF_X); end
        total++; if (x4 !== OVF_X) begin bad++; $display("[TB] FAIL ovf_final got=%0d want=%0d", x4, OVF_X); end
        total++; if (bus.ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", bus.ovf); end
        launch(8'sd32);
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear_on_start got=%b want=0", bus.ovf); end
        total++; if (bus.x !== 8'sd32) begin bad++; $display("[TB] FAIL ovf_reload_x got=%0d want=32", bus.x); end
        for (int i = 0; i < 4; i++) feed(2'b00);
        wait_done(waited);
        total++; if (waited !== 0) begin bad++; $display("[TB] FAIL ovf_rerun_done got=%0d want=0", waited); end
        step();
    endtask

    task automatic test_stalls();
        logic signed [7:0] x1, x2, x3, x4;
        int lat, sd, rl, pulses;
        run_seq(8'sd32, 8'b01_11_00_01, 2, 1'b1, x1, x2, x3, x4, lat, sd, rl, pulses);
        total++; if (x4 !== 8'sd54) begin bad++; $display("[TB] FAIL stall_x got=%0d want=54", x4); end
        total++; if (lat !== 8) begin bad++; $display("[TB] FAIL stall_latency got=%0d want=8", lat); end
        total++; if (sd !== 0) begin bad++; $display("[TB] FAIL stall_done_early got=%0d want=0", sd); end
        total++; if (rl !== 0) begin bad++; $display("[TB] FAIL stall_ready_ena_low got=%0d want=0", rl); end
        total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL stall_done_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_reset_mid_run();
        logic signed [7:0] x1, x2, x3, x4;
        int lat, sd, rl, pulses, dones;
        launch(8'sd32);
        feed(2'b01);
        feed(2'b00);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.x !== 8'sd0) begin bad++; $display("[TB] FAIL midrst_x got=%0d want=0", bus.x); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", bus.busy); end
        #2 rst_n = 1'b1;
        step();
        dones = 0;
        bus.dig_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.done || bus.busy) dones++;
            step();
        end
        bus.dig_valid = 1'b0;
        total++; if (dones !== 0) begin bad++; $display("[TB] FAIL midrst_no_done got=%0d want=0", dones); end
        run_seq(8'sd32, 8'b01_11_00_01, 0, 1'b0, x1, x2, x3, x4, lat, sd, rl, pulses);
        total++; if (x4 !== 8'sd54) begin bad++; $display("[TB] FAIL midrst_rerun_x got=%0d want=54", x4); end
    endtask

    task automatic test_edge_cases();
        logic signed [7:0] x1, x2, x3, x4;
        int lat, sd, rl, pulses, waited;
        run_seq(8'sd32, 8'b01_11_10_01, 0, 1'b0, x1, x2, x3, x4, lat, sd, rl, pulses);
        total++; if (x2 !== 8'sd64) begin bad++; $display("[TB] FAIL rsv_x2 got=%0d want=64", x2); end
        total++; if (x4 !== 8'sd54) begin bad++; $display("[TB] FAIL rsv_final got=%0d want=54", x4); end

        launch(8'sd32);
        feed(2'b01);
        bus.start = 1'b1;
        bus.x0    = 8'sd5;
        step();
        bus.start = 1'b0;
        total++; if (bus.x !== 8'sd64) begin bad++; $display("[TB] FAIL start_in_run_x got=%0d want=64", bus.x); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL start_in_run_busy got=%b want=1", bus.busy); end
        feed(2'b00);
        feed(2'b11);
        feed(2'b01);
        wait_done(waited);
        total++; if (waited !== 0) begin bad++; $display("[TB] FAIL start_in_run_done got=%0d want=0", waited); end
        total++; if (bus.x !== 8'sd54) begin bad++; $display("[TB] FAIL start_in_run_final got=%0d want=54", bus.x); end

        bus.start = 1'b1;
        bus.x0    = 8'sd10;
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL start_in_done_busy got=%b want=0", bus.busy); end
        total++; if (bus.x !== 8'sd54) begin bad++; $display("[TB] FAIL start_in_done_x got=%0d want=54", bus.x); end
        step();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL start_after_done_busy got=%b want=1", bus.busy); end
        total++; if (bus.x !== 8'sd10) begin bad++; $display("[TB] FAIL start_after_done_x got=%0d want=10", bus.x); end
        feed(2'b01);
        feed(2'b00);
        feed(2'b00);
        feed(2'b00);
        wait_done(waited);
        total++; if (waited !== 0) begin bad++; $display("[TB] FAIL b2b_done got=%0d want=0", waited); end
        total++; if (bus.x !== 8'sd20) begin bad++; $display("[TB] FAIL b2b_final got=%0d want=20", bus.x); end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_stalls();
        test_reset_mid_run();
        test_edge_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bkm_shift_add_iter.md
# bkm_shift_add_iter

Iterative shift-and-add engine for the BKM datapath. It sits directly downstream of the signed `add_subb` cell and instantiates it as its adder. The engine loads a signed operand and consumes one signed digit per handshake from the upstream digit selector. Each accepted digit applies one step `x <= x + d_n * (x >>> n)`, for n = 0 .. N_ITER-1. When the last step completes it flags `done`.

## Interface
- `W`, 16, datapath width (signed two's complement).
- `N_ITER`, 16, number of iterations; legal range 1 ≤ N_ITER ≤ W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable; low freezes all state, `dig_ready` and `done` forced 0.
- `start` in 1: load request; sampled only in IDLE.
- `x0` in W: signed initial operand, captured with `start`.
- `dig_valid` in 1: upstream digit valid.
- `dig_d` in 2: digit code: 00 = 0, 01 = +1, 11 = -1, 10 = reserved (treated as 0).
- `dig_ready` out 1: engine accepts a digit this cycle.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse after the final iteration.
- `x` out W: signed accumulator.
- `ovf` out 1: sticky signed-overflow flag, cleared on `start`.

## Operation
- The FSM has three states: IDLE, RUN, DONE. The iteration counter `n` is `$clog2(N_ITER)` bits wide, minimum 1.
- **IDLE:** when `start & ena`, load `x <= x0`, `n <= 0`, `ovf <= 0`, then go to RUN. `x` otherwise holds its last result.
- **RUN:**
  - `dig_ready = ena` in this state.
  - A handshake is `dig_valid & dig_ready`. On a handshake the step is applied and `n` increments.
  - If `n == N_ITER-1` at the handshake, go to DONE.
  - Without a handshake, all state holds.
  - `start` is ignored in this state.
- **DONE:** `done = 1` for one cycle (gated by `ena`), then go to IDLE.
- **Step datapath:**
  - `b = x >>> n`, an arithmetic shift that fills with the sign bit.
  - `add_subb` is driven with `subb_a = 0`, `subb_b = (d == -1)`, `a = x`, `b = b`.
  - For d = 0, `x` holds and the adder result is discarded.
- **Overflow:** signed overflow occurs when the sign of `a` equals the sign of the effective `b` and differs from the sign of `s`. Any overflow in the run sets `ovf`, which stays set until the next `start`.

## Timing
- **Reset values** (asynchronous on `rst_n` low): state = IDLE, `n` = 0, `x` = 0, `ovf` = 0, `dig_ready` = 0, `busy` = 0, `done` = 0.
- **Latency:**
  - The `start` edge enters RUN, and `dig_ready` is high in the next cycle.
  - With `dig_valid` held high, the final handshake occurs N_ITER cycles after the `start` edge.
  - `done` asserts in the cycle after the final handshake, and `x` is final in that same cycle.
  - Total latency from the `start` edge to the `done` edge is N_ITER+1 cycles.
- **Stalls:** `dig_valid` gaps or `ena` low extend latency one cycle per stall, with no state change.
- **Reset mid-run:** the engine aborts to IDLE immediately, `x` clears, and no `done` is produced.
- **Back-to-back runs:** a `start` asserted during the `done` cycle is ignored. A new run may start at the earliest in the cycle after `done`.

## Configuration
- Macro `BKM_SHIFT_ADD_SAT_EN`.
  - **Defined:** an overflowing step saturates `x` to `2^(W-1)-1` (positive overflow) or `-2^(W-1)` (negative overflow). `ovf` is still set.
  - **Undefined:** an overflowing step wraps modulo 2^W, and `ovf` is set.

## Structure
- Package `bkm_pkg` holds:
  - digit code constants `DIG_ZERO`, `DIG_POS`, `DIG_NEG`, `DIG_RSV`;
  - the FSM state encoding `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- One sub-module: the existing `add_subb #(.W(W))`, instantiated as `u_add_subb`. The shifter, saturation logic, counter and FSM are local.

## Test plan
All scenarios use W = 8, N_ITER = 4.
- **Basic run:** `x0=32`, digits +1, 0, -1, +1 streamed back-to-back → intermediate `x` = 64, 64, 48, 54. `done` arrives 5 cycles after the `start` edge, `ovf = 0`.
- **Negative operand:** `x0=-40`, digits 0, +1, 0, -1 → `x` = -40, -60, -60, -52 (-60 >>> 3 = -8). `ovf = 0`.
- **Overflow:** `x0=100`, digits +1, 0, 0, 0 → `ovf = 1` and a final `x` of:
  - -56 without `BKM_SHIFT_ADD_SAT_EN`;
  - 127 with it.
- **Stalls:** basic run with `dig_valid` low for 2 cycles after digit 1 and `ena` low for 1 cycle after digit 2 → same result 54, `done` at cycle 8. No `done` while stalled, and `dig_ready` stays 0 while `ena` is low.
- **Reset mid-run:** pulse `rst_n` low after digit 2 → `x = 0`, `busy = 0`, no `done`. A new run with `start`, `x0=32` and the basic digits gives 54.
- **Edge cases:**
  - reserved code 10 behaves as 0;
  - `start` asserted during RUN is ignored;
  - `start` during the `done` cycle is ignored, and `start` in the next cycle launches a new run.
